// File: rtl/vsim_send.sv
// vsim_send: simulation-side transmitter toward the host.
// Accepts beats over an EN/RDY handshake, frames them into messages using
// the 16-bit length field of each header beat, and buffers {last, beat}
// in a small FIFO drained by the host through a valid/ready port.
//
// Ports:
//   CLK        clock, all logic on the rising edge
//   RST        synchronous reset, active-high
//   EN_beat    design offers a beat this cycle
//   RDY_beat   block can accept a beat this cycle
//   beat       beat data
//   out_valid  FIFO head is valid
//   out_ready  host consumes the head this cycle
//   out_beat   FIFO head data
//   out_last   FIFO head is the final beat of its message
//   msg_count  completed messages drained (wraps)
//   err        sticky protocol-error flag (EN_beat while RDY_beat=0)
//
// Framing states:
//   state | meaning
//   HDR   | next accepted beat is a message header
//   BODY  | next accepted beat is a body beat; remaining beats left
module vsim_send #(
  parameter int width = 32,
  parameter int depth = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN_beat,
  output logic             RDY_beat,
  input  logic [width-1:0] beat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_beat,
  output logic             out_last,
  output logic [15:0]      msg_count,
  output logic             err
);

  localparam int aw = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [aw:0] full_cnt = (aw+1)'(depth);

  typedef enum logic {HDR = 1'b0, BODY = 1'b1} state_t;

  state_t          state;
  logic [15:0]     remaining;
  logic [aw-1:0]   rd_ptr;
  logic [aw-1:0]   wr_ptr;
  logic [aw:0]     count;
  logic [width:0]  mem [depth];

  logic            push;
  logic            pop;
  logic            push_last;
  logic [15:0]     hdr_len;

  // Ready depends only on registered occupancy, never on out_ready.
  assign RDY_beat  = !RST && (count != full_cnt);
  assign push      = EN_beat && RDY_beat;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  // Storage is not reset; gating the head keeps out_* at zero when empty.
  assign out_beat  = out_valid ? mem[rd_ptr][width-1:0] : '0;
  assign out_last  = out_valid ? mem[rd_ptr][width]     : 1'b0;

  assign hdr_len   = beat[15:0];
  // A header with length 0 or 1 is a single-beat message.
  assign push_last = (state == HDR) ? (hdr_len <= 16'd1) : (remaining == 16'd1);

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= {push_last, beat};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      state     <= HDR;
      remaining <= '0;
      msg_count <= '0;
      err       <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (EN_beat && !RDY_beat) begin
        err <= 1'b1;
      end
      if (pop && out_last) begin
        msg_count <= msg_count + 16'd1;
      end

      if (push) begin
        case (state)
          HDR: begin
            if (hdr_len > 16'd1) begin
              remaining <= hdr_len - 16'd1;
              state     <= BODY;
            end
          end
          BODY: begin
            if (remaining != 16'd0) begin
              remaining <= remaining - 16'd1;
            end
            if (remaining <= 16'd1) begin
              state <= HDR;
            end
          end
          default: state <= HDR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vsim_send.sv
// Testbench for vsim_send: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_vsim_send;

  localparam int W = 32;
  localparam int D = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          EN_beat;
  logic          RDY_beat;
  logic [W-1:0]  beat;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_beat;
  logic          out_last;
  logic [15:0]   msg_count;
  logic          err;

  vsim_send #(.width(W), .depth(D)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN_beat   (EN_beat),
    .RDY_beat  (RDY_beat),
    .beat      (beat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_beat  (out_beat),
    .out_last  (out_last),
    .msg_count (msg_count),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO contents as {last, beat}, beats left in the
  // current message (0 = next beat is a header), drained-message count.
  logic [W:0]  q[$];
  int          left = 0;
  logic [15:0] mc = '0;
  logic        e_err = 1'b0;
  bit          after_rst = 0;
  bit          seen55 = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs before the edge,
  // then advance the model with what the edge does.
  task automatic step(input logic en, input logic [W-1:0] b, input logic ordy, input logic rst);
    logic       exp_rdy;
    logic [W:0] e;
    int         len;
    bit         do_pop;
    RST       = rst;
    EN_beat   = en;
    beat      = b;
    out_ready = ordy;
    @(negedge CLK);
    exp_rdy = !rst && (q.size() < D);
    check_eq("rdy", RDY_beat, exp_rdy);
    check_eq("valid", out_valid, q.size() != 0);
    check_eq("msg_count", msg_count, mc);
    check_eq("err", err, e_err);
    if (q.size() != 0) begin
      check_eq("beat", out_beat, q[0][W-1:0]);
      check_eq("last", out_last, q[0][W]);
    end else if (after_rst) begin
      check_eq("rst_beat", out_beat, 0);
      check_eq("rst_last", out_last, 0);
    end
    if (out_valid && out_beat == 32'h55) seen55 = 1;
    @(posedge CLK);
    if (rst) begin
      q.delete();
      left      = 0;
      mc        = '0;
      e_err     = 1'b0;
      after_rst = 1;
    end else begin
      after_rst = 0;
      do_pop = (q.size() != 0) && ordy;
      if (en && !exp_rdy) e_err = 1'b1;
      if (do_pop) begin
        e = q.pop_front();
        if (e[W]) mc++;
      end
      if (en && exp_rdy) begin
        if (left == 0) begin
          len  = int'(b[15:0]);
          left = (len == 0) ? 1 : len;
        end
        left--;
        q.push_back({left == 0, b});
      end
    end
    #1;
  endtask

  initial begin
    logic [W-1:0] r;
    logic         en_r;
    logic         rdy_r;
    logic         rst_r;

    RST = 1'b1; EN_beat = 1'b0; beat = '0; out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    after_rst = 1;

    // Single message, no backpressure.
    step(1'b1, 32'h3, 1'b1, 1'b0);
    step(1'b1, 32'hA, 1'b1, 1'b0);
    step(1'b1, 32'hB, 1'b1, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    check_eq("single_mc", msg_count, 1);

    // Fill the FIFO with part of an L=10 message, then a dropped beat.
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 32'd10, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) step(1'b1, 32'h100 + i, 1'b0, 1'b0);
    check_eq("full_rdy", RDY_beat, 0);
    seen55 = 0;
    step(1'b1, 32'h55, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check_eq("err_set", err, 1);

    // Full with simultaneous drain, continuing across pointer wrap.
    for (int i = 0; i < 20; i++) step(1'b1, 32'h200 + i, 1'b1, 1'b0);
    repeat (12) step(1'b0, '0, 1'b1, 1'b0);
    check_eq("no55", seen55, 0);

    // Degenerate lengths.
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h1, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    check_eq("deg_mc", msg_count, 2);

    // Reset mid-message.
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 32'h5, 1'b0, 1'b0);
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h12, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    check_eq("mid_valid", out_valid, 0);
    check_eq("mid_mc", msg_count, 0);
    check_eq("mid_err", err, 0);
    step(1'b1, 32'h2, 1'b1, 1'b0);
    step(1'b1, 32'h7, 1'b1, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    check_eq("mid_after_mc", msg_count, 1);

    // Randomized traffic with short message lengths and rare resets.
    for (int i = 0; i < 2000; i++) begin
      r       = $urandom();
      r[15:0] = 16'($urandom_range(0, 4));
      en_r    = ($urandom_range(0, 3) != 0);
      rdy_r   = ($urandom_range(0, 2) != 0);
      rst_r   = ($urandom_range(0, 199) == 0);
      step(en_r, r, rdy_r, rst_r);
    end

    // msg_count wrap through 65536 single-beat messages.
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 65536; i++) step(1'b1, 32'h1, 1'b1, 1'b0);
    check_eq("pre_wrap", msg_count, 32'hFFFF);
    step(1'b0, '0, 1'b1, 1'b0);
    check_eq("wrap", msg_count, 0);
    check_eq("wrap_empty", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
